instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetches 32-bit instructions from the instruction memory bus into a small prefetch FIFO and
//  presents them, with their PC, to the decode stage (decoder + immediate generator) via
//  valid/ready. Accepts redirects (branch/jump/trap) from execute, discarding stale fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  4              prefetch entries; power of two, >= 2
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  mem_req       out  1   read request; held until mem_ack
//  mem_addr      out  32  word address of request (bits[1:0] = 0)
//  mem_ack       in   1   read data valid this cycle; completes request
//  mem_rdata     in   32  instruction word returned with mem_ack
//  instr_valid   out  1   FIFO head valid
//  instr_ready   in   1   decode consumes head when valid & ready
//  instr         out  32  head instruction (32'h0000_0013 NOP when !instr_valid)
//  instr_pc      out  32  PC of head instruction
//  redirect      in   1   flush pipeline, restart fetch at redirect_pc
//  redirect_pc   in   32  new fetch PC
//  instr_fault   out  1   head entry is a misaligned-fetch fault (only with FETCH_ALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0, instr_fault=0,
//   fetch_pc=RESET_PC, FIFO empty, state=IDLE.
//  One outstanding request max. FSM states:
//   IDLE : if free slots (FIFO_DEPTH - count) >= 1 and !redirect -> assert mem_req, mem_addr=fetch_pc, go REQ.
//   REQ  : mem_req held, mem_addr stable. On mem_ack: push {fetch_pc, mem_rdata}, fetch_pc += 4
//          (32-bit wrap, 32'hFFFF_FFFC -> 0), go IDLE (new request earliest next cycle).
//          On redirect without mem_ack -> DRAIN. On redirect with mem_ack -> data discarded, IDLE.
//   DRAIN: mem_req deasserted; the late mem_ack is discarded; -> IDLE. Further redirect in DRAIN
//          updates fetch_pc only.
//  Bus protocol note: mem_ack in DRAIN is tolerated whether or not mem_req is high.
//  Redirect (highest priority): same cycle FIFO cleared, pop ignored, fetch_pc <= redirect_pc;
//   instr_valid=0 next cycle. First redirected instruction visible no earlier than 2 cycles later.
//  Pop: valid & ready removes head. Push+pop same cycle on full FIFO allowed (count unchanged);
//   push to full FIFO never occurs (issue gated by free slots, counting the outstanding request).
//  Latency: mem_ack cycle -> instr_valid next cycle when FIFO was empty (registered output).
//  Reset asserted mid-transaction: all state cleared immediately; later mem_ack ignored (IDLE).
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 pushes one entry {pc=redirect_pc,
//   instr=NOP, fault=1} with no bus request; fetch stalls (IDLE, no issue) until next redirect.
//  Undefined: redirect_pc[1:0] forced to 0; instr_fault tied 0; no fault entry.
// STRUCTURE
//  Shared header fetch_defs.vh: state encodings (IDLE/REQ/DRAIN), NOP_INSTR = 32'h0000_0013.
//  Sub-module fetch_fifo: synchronous FIFO (WIDTH=65 {fault,pc,instr}, DEPTH), push/pop/clear,
//   count output; head registered. Top holds FSM, fetch_pc and issue logic.
// TESTING
//  1 Reset release, mem_ack 1 cycle after each req -> words at PC 0,4,8,12 emerge in order, instr_pc matches.
//  2 instr_ready=0 with zero-latency memory -> exactly FIFO_DEPTH (4) accepted, mem_req then low; pop one -> one new req.
//  3 redirect to 32'h0000_0100 while REQ pending, ack 3 cycles later -> ack discarded, next mem_addr=0x100,
//    no pre-redirect instr after redirect.
//  4 redirect same cycle as mem_ack and pop -> FIFO empty next cycle, data dropped, fetch from redirect_pc.
//  5 redirect_pc=32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
//  6 FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 -> instr_valid, instr_fault=1, instr_pc=0x102, no mem_req
//    until redirect 0x200; macro off -> fetch at 0x100, instr_fault=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch FSM states, prefetch entry layout and NOP encoding
package instruction_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: prefetch FIFO with clear, push/pop and occupancy count; a push may coincide with clear
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, wr_base;
  assign wr_base = clear ? '0 : wr_q;
  assign rdata   = mem_q[rd_q];
  // Pointers and count; clear restarts both pointers so a same-cycle push lands at slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      rd_q  <= clear ? '0 : rd_q + AW'(pop);
      wr_q  <= wr_base + AW'(push);
      count <= (clear ? '0 : count - CW'(pop)) + CW'(push);
    end
  end
  // Entry storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_base] <= wdata;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding instruction fetch into a prefetch FIFO with redirect flush; FETCH_ALIGN_CHECK_EN enables misaligned-redirect fault entries
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          stall_q, stall_d;
  logic [CW-1:0] count;
  logic          push, pop, bad_pc;
  fetch_entry_t  push_entry, head;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_pc = redirect_pc[1:0] != 2'b00;
`else
  assign bad_pc = 1'b0;
`endif
  assign mem_req     = state_q == REQ;
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = count != '0;
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc : 32'h0;
  assign instr_fault = instr_valid & head.fault;
  assign pop         = instr_valid & instr_ready & ~redirect;
  // Next state: redirect wins; otherwise issue when a slot is free, complete on ack, drain a stale ack
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stall_d    = stall_q;
    push       = 1'b0;
    push_entry = '{fault: bad_pc, pc: redirect_pc, instr: NOP_INSTR};
    if (redirect) begin
      state_d    = (state_q != IDLE && !mem_ack) ? DRAIN : IDLE;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      stall_d    = bad_pc;
      push       = bad_pc;
    end else begin
      case (state_q)
        IDLE:    state_d = (count < CW'(FIFO_DEPTH) && !stall_q) ? REQ : IDLE;
        REQ: begin
          if (mem_ack) begin
            state_d    = IDLE;
            fetch_pc_d = fetch_pc_q + 32'd4;
            push       = 1'b1;
            push_entry = '{fault: 1'b0, pc: fetch_pc_q, instr: mem_rdata};
          end
        end
        DRAIN:   state_d = mem_ack ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end
  // FSM state, fetch PC and misaligned-redirect stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stall_q    <= stall_d;
    end
  end
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (count)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic against a queue-level reference model plus directed scenarios
module tb_instruction_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed { logic f; logic [31:0] pc; logic [31:0] ins; } ent_t;
  logic clk = 0, reset = 1, mem_req, mem_ack = 0, instr_valid, instr_ready = 0, redirect = 0, instr_fault;
  logic [31:0] mem_addr, mem_rdata = 0, instr, instr_pc, redirect_pc = 0;
  int vectors = 0, miscompares = 0;
  ent_t q[$];
  logic [31:0] log_pc[$];
  logic [31:0] exp_fetch = 0, req_addr = 0, last_req = 0, rpc_n = 0;
  bit busy, live, stall, armed, exp_req, acked, rdy_n, redir_n, redir_on_ack, fired, fire_valid;
  int lat, lat_lo, lat_hi, n_req;
  always #5 clk = ~clk;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .redirect(redirect), .redirect_pc(redirect_pc), .instr_fault(instr_fault)
  );
  function automatic logic [31:0] word(logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0135_7913;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    logic ack, rd, pop, idle;
    logic [31:0] tgt;
    @(negedge clk);
    chk("valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr", instr, q[0].ins);
      chk("instr_pc", instr_pc, q[0].pc);
      chk("fault", instr_fault, q[0].f);
    end else begin
      chk("instr_nop", instr, NOP);
      chk("instr_pc0", instr_pc, 0);
      chk("fault0", instr_fault, 0);
    end
    if (armed) chk("issue", mem_req, exp_req);
    if (acked) chk("idle_after_ack", mem_req, 0);
    if (busy) chk("req_hold", mem_req, live);
    if (busy && live) chk("addr_hold", mem_addr, req_addr);
    if (!busy) chk("addr", mem_addr, exp_fetch);
    idle = !busy && mem_req !== 1'b1;
    if (!busy && mem_req === 1'b1) begin
      busy = 1; live = 1; req_addr = mem_addr; last_req = mem_addr; n_req++;
      lat = $urandom_range(lat_hi, lat_lo);
    end
    ack = busy && lat == 0;
    if (busy && lat > 0) lat--;
    rd = redir_n;
    if (redir_on_ack && ack) begin
      rd = 1; fired = 1; fire_valid = instr_valid; redir_on_ack = 0;
    end
    tgt = rpc_n;
    instr_ready = rdy_n; redirect = rd; redirect_pc = tgt; mem_ack = ack;
    mem_rdata = ack ? word(req_addr) : $urandom();
    pop = q.size() != 0 && rdy_n && !rd;
    if (pop) log_pc.push_back(instr_pc);
    armed = idle;
    exp_req = q.size() < DEPTH && !stall && !rd;
    acked = ack;
    if (rd) begin
      q.delete(); live = 0; exp_fetch = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
      stall = tgt[1:0] != 2'b00;
      if (stall) q.push_back('{f: 1'b1, pc: tgt, ins: NOP});
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (ack && live) begin
        q.push_back('{f: 1'b0, pc: req_addr, ins: word(req_addr)});
        exp_fetch = req_addr + 32'd4;
      end
    end
    if (ack) begin busy = 0; live = 0; end
    redir_n = 0;
  endtask
  task automatic do_reset(bit stray);
    @(negedge clk);
    reset = 1; instr_ready = 0; redirect = 0; mem_ack = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 0);
    chk("rst_fault", instr_fault, 0);
    repeat (2) @(negedge clk);
    q.delete(); log_pc.delete();
    exp_fetch = 0; busy = 0; live = 0; stall = 0; acked = 0; n_req = 0;
    redir_n = 0; redir_on_ack = 0; fired = 0;
    armed = 1; exp_req = 1;
    mem_ack = stray; reset = 0;
  endtask
  initial begin
    int n0;
    lat_lo = 0; lat_hi = 3; rdy_n = 0;
    do_reset(0);
    rdy_n = 1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 60 && log_pc.size() < 4; i++) step();
    chk("t1_count", log_pc.size() >= 4, 1);
    if (log_pc.size() >= 4) for (int i = 0; i < 4; i++) chk("t1_pc", log_pc[i], 32'(i * 4));
    do_reset(1);
    rdy_n = 0; lat_lo = 0; lat_hi = 0;
    repeat (20) step();
    chk("t2_reqs", n_req, 4);
    chk("t2_valid", instr_valid, 1);
    chk("t2_req_low", mem_req, 0);
    rdy_n = 1; step(); rdy_n = 0;
    repeat (8) step();
    chk("t2_refill", n_req, 5);
    chk("t2_req_low2", mem_req, 0);
    do_reset(0);
    rdy_n = 1; lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("t3_busy", busy, 1);
    redir_n = 1; rpc_n = 32'h100; step(); log_pc.delete();
    n0 = n_req;
    for (int i = 0; i < 20 && n_req == n0; i++) step();
    chk("t3_addr", last_req, 32'h100);
    for (int i = 0; i < 20 && log_pc.size() == 0; i++) step();
    chk("t3_first", log_pc.size() != 0 ? log_pc[0] : 32'hDEAD_BEEF, 32'h100);
    do_reset(0);
    rdy_n = 0; lat_lo = 0; lat_hi = 0;
    repeat (5) step();
    rdy_n = 1; rpc_n = 32'h300; redir_on_ack = 1;
    for (int i = 0; i < 10 && !fired; i++) step();
    chk("t4_fired", fired, 1);
    chk("t4_popping", fire_valid, 1);
    n0 = n_req; step();
    chk("t4_empty", instr_valid, 0);
    for (int i = 0; i < 10 && n_req == n0; i++) step();
    chk("t4_addr", last_req, 32'h300);
    rdy_n = 1; lat_lo = 0; lat_hi = 2;
    redir_n = 1; rpc_n = 32'hFFFF_FFFC; step(); log_pc.delete();
    for (int i = 0; i < 40 && log_pc.size() < 2; i++) step();
    chk("t5_count", log_pc.size() >= 2, 1);
    if (log_pc.size() >= 2) begin
      chk("t5_pc0", log_pc[0], 32'hFFFF_FFFC);
      chk("t5_pc1", log_pc[1], 32'h0);
    end
    redir_n = 1; rpc_n = 32'h102; step(); n0 = n_req; log_pc.delete();
`ifdef FETCH_ALIGN_CHECK_EN
    rdy_n = 0; step();
    chk("t6_valid", instr_valid, 1);
    chk("t6_fault", instr_fault, 1);
    chk("t6_pc", instr_pc, 32'h102);
    repeat (8) step();
    chk("t6_stall", n_req, n0);
    redir_n = 1; rpc_n = 32'h200; rdy_n = 1; step();
    for (int i = 0; i < 20 && n_req == n0; i++) step();
    chk("t6_addr", last_req, 32'h200);
`else
    for (int i = 0; i < 20 && n_req == n0; i++) step();
    chk("t6_addr", last_req, 32'h100);
    for (int i = 0; i < 20 && log_pc.size() == 0; i++) step();
    chk("t6_first", log_pc.size() != 0 ? log_pc[0] : 32'hDEAD_BEEF, 32'h100);
`endif
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      rdy_n = $urandom_range(0, 9) < (((i / 500) % 2) != 0 ? 2 : 8);
      if ($urandom_range(0, 39) == 0) begin
        redir_n = 1;
        rpc_n = $urandom();
        if ($urandom_range(0, 3) != 0) rpc_n[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) rpc_n = 32'hFFFF_FFF4;
      end
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 1) == 1);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
